// File: rtl/soc_system_pio_pkg.sv
// Shared constants and helpers for the edge-capturing PIO input block.
// Register word addresses, edge-type encodings and write-decode helpers.
// No logic of its own; imported by the sync/edge stage and the top level.
package soc_system_pio_pkg;

  // Avalon-MM word addresses of the register map
  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_MASK    = 3'd1;
  localparam logic [2:0] ADDR_EDGECAP = 3'd2;
  localparam logic [2:0] ADDR_EDGECNT = 3'd3;
  localparam logic [2:0] ADDR_STATUS  = 3'd4;

  // EDGE_TYPE parameter encodings
  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  // Edge counter saturates here instead of wrapping
  localparam logic [31:0] EDGECNT_MAX = 32'hFFFF_FFFF;

  // One-hot view of which writable register a bus write targets.
  // DATA, STATUS and the unmapped words have no entry, so writes to them
  // fall through with every field clear.
  typedef struct packed {
    logic mask_wr;
    logic cap_clr;
    logic cnt_clr;
  } wr_dec_t;

  function automatic wr_dec_t decode_write(input logic wr_en, input logic [2:0] addr);
    wr_dec_t d;
    d         = '0;
    d.mask_wr = wr_en && (addr == ADDR_MASK);
    d.cap_clr = wr_en && (addr == ADDR_EDGECAP);
    d.cnt_clr = wr_en && (addr == ADDR_EDGECNT);
    return d;
  endfunction

  // Increment that sticks at all-ones
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == EDGECNT_MAX) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/soc_system_pio_sync_edge.sv
// Synchronises asynchronous inputs and flags the selected edge type per bit.
// Latency: SYNC_STAGES clocks from pin to sync, edge pulse valid in that same cycle.
// No backpressure: samples every clock; edge pulses last exactly one cycle.
module soc_system_pio_sync_edge
  import soc_system_pio_pkg::*;
#(
  parameter int WIDTH       = 1,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] edge_hit
);

  // Stage 0 is the metastability-catching flop; the last stage is the
  // clean synchronised value. Packed so the shift is a single concatenation.
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  prev;

  // Shift the raw pins through the synchroniser chain
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // Remember last cycle's synchronised value. Resetting to 0 means a pin
  // held high across reset shows up as a rising edge once released.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev <= '0;
    end else begin
      prev <= sync;
    end
  end

  // Edge flavour is fixed at elaboration; unknown encodings behave as "any"
  if (EDGE_TYPE == EDGE_RISING) begin : g_rise
    assign edge_hit = sync & ~prev;
  end else if (EDGE_TYPE == EDGE_FALLING) begin : g_fall
    assign edge_hit = ~sync & prev;
  end else begin : g_any
    assign edge_hit = sync ^ prev;
  end

endmodule

// File: rtl/soc_system_pio_in_edge.sv
// Avalon-MM PIO input port with per-bit edge capture, edge counter and masked IRQ.
// Latency: read data 1 clock after address; pin edge to EDGECAP in SYNC_STAGES+1 clocks.
// No backpressure: slave accepts a write every cycle and never stalls reads.
module soc_system_pio_in_edge
  import soc_system_pio_pkg::*;
#(
  parameter int WIDTH       = 1,
  parameter int EDGE_TYPE   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync_data;
  logic [WIDTH-1:0] edge_hit;

  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] edge_cap;
  logic [31:0]      edge_cnt;

  logic             wr_en;
  wr_dec_t          wdec;
  logic [WIDTH-1:0] cap_clr;
  logic [WIDTH-1:0] cap_nxt;
  logic [31:0]      cnt_nxt;
  logic [31:0]      rd_mux;

  // Only the low WIDTH bits of writedata carry meaning; fold the rest so the
  // upper bits are visibly consumed.
  logic             unused_wdata;
  assign unused_wdata = ^writedata;

  soc_system_pio_sync_edge #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_TYPE   (EDGE_TYPE)
  ) u_sync_edge (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_port  (in_port),
    .sync     (sync_data),
    .edge_hit (edge_hit)
  );

  assign wr_en = chipselect && !write_n;
  assign wdec  = decode_write(wr_en, address);

  // Next EDGECAP: clear the written-1 bits, then OR in new edges so a
  // capture landing in the same cycle as its clear is never lost.
  always_comb begin
    cap_clr = '0;
    if (wdec.cap_clr) begin
      cap_clr = writedata[WIDTH-1:0];
    end
    cap_nxt = (edge_cap & ~cap_clr) | edge_hit;
  end

  // Next EDGECNT: a clear beats a coincident edge; otherwise count cycles
  // with at least one edge, holding at all-ones.
  always_comb begin
    cnt_nxt = edge_cnt;
    if (wdec.cnt_clr) begin
      cnt_nxt = '0;
    end else if (|edge_hit) begin
      cnt_nxt = sat_inc(edge_cnt);
    end
  end

  // Interrupt mask register, written directly from the bus
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask <= '0;
    end else if (wdec.mask_wr) begin
      mask <= writedata[WIDTH-1:0];
    end
  end

  // Sticky per-bit edge capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_cap <= '0;
    end else begin
      edge_cap <= cap_nxt;
    end
  end

  // Saturating count of cycles containing any edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_cnt <= '0;
    end else begin
      edge_cnt <= cnt_nxt;
    end
  end

  // Level interrupt straight from the capture and mask flops, so bus inputs
  // only reach it through a register: a MASK or W1C write shows up one
  // cycle later.
  assign irq = |(edge_cap & mask);

  // Read mux over the current (pre-update) register values. Bits at or
  // above WIDTH and the unmapped words read as zero.
  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:    rd_mux[WIDTH-1:0] = sync_data;
      ADDR_MASK:    rd_mux[WIDTH-1:0] = mask;
      ADDR_EDGECAP: rd_mux[WIDTH-1:0] = edge_cap;
      ADDR_EDGECNT: rd_mux            = edge_cnt;
      ADDR_STATUS: begin
        rd_mux[0]    = irq;
        rd_mux[15:8] = 8'(WIDTH);
      end
      default:      rd_mux            = '0;
    endcase
  end

  // Read data is registered every clock regardless of chipselect, giving a
  // fixed one-cycle read latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_soc_system_pio_in_edge.sv
// Directed bench for soc_system_pio_in_edge: two instances, one 4-bit
// rising-edge port (a) and one 1-bit any-edge port (b), sharing clock/reset.
module tb_soc_system_pio_in_edge;
  import soc_system_pio_pkg::*;

  logic        clk;
  logic        reset_n;

  logic [2:0]  address_a, address_b;
  logic        chipselect_a, chipselect_b;
  logic        write_n_a, write_n_b;
  logic [31:0] writedata_a, writedata_b;
  logic [3:0]  in_a;
  logic [0:0]  in_b;
  logic [31:0] readdata_a, readdata_b;
  logic        irq_a, irq_b;

  int vectors     = 0;
  int miscompares = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  soc_system_pio_in_edge #(.WIDTH(4), .EDGE_TYPE(0), .SYNC_STAGES(2)) dut_a (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address_a),
    .chipselect (chipselect_a),
    .write_n    (write_n_a),
    .writedata  (writedata_a),
    .in_port    (in_a),
    .readdata   (readdata_a),
    .irq        (irq_a)
  );

  soc_system_pio_in_edge #(.WIDTH(1), .EDGE_TYPE(2), .SYNC_STAGES(2)) dut_b (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address_b),
    .chipselect (chipselect_b),
    .write_n    (write_n_b),
    .writedata  (writedata_b),
    .in_port    (in_b),
    .readdata   (readdata_b),
    .irq        (irq_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one write cycle from a negedge; returns on the following negedge
  task automatic bus_write(input int which, input logic [2:0] addr,
                           input logic [31:0] data, input logic cs = 1'b1);
    if (which == 0) begin
      address_a = addr; writedata_a = data; chipselect_a = cs; write_n_a = 1'b0;
    end else begin
      address_b = addr; writedata_b = data; chipselect_b = cs; write_n_b = 1'b0;
    end
    @(negedge clk);
    chipselect_a = 1'b0; write_n_a = 1'b1;
    chipselect_b = 1'b0; write_n_b = 1'b1;
  endtask

  // Present an address, wait one clock, compare the registered read data
  task automatic expect_reg(input string tag, input int which,
                            input logic [2:0] addr, input logic [31:0] exp);
    logic [31:0] got;
    if (which == 0) address_a = addr; else address_b = addr;
    @(negedge clk);
    got = (which == 0) ? readdata_a : readdata_b;
    check(tag, got, exp);
  endtask

  initial begin
    reset_n      = 1'b0;
    address_a    = '0; address_b    = '0;
    chipselect_a = 1'b0; chipselect_b = 1'b0;
    write_n_a    = 1'b1; write_n_b    = 1'b1;
    writedata_a  = '0; writedata_b  = '0;
    in_a         = 4'h0; in_b         = 1'b0;

    // ---- reset state ----
    repeat (2) @(negedge clk);
    check("rst_rdata_a", readdata_a, 32'h0);
    check("rst_irq_a",   {31'h0, irq_a}, 32'h0);
    reset_n = 1'b1;
    expect_reg("rst_data_a",   0, ADDR_DATA,    32'h0);
    expect_reg("rst_mask_a",   0, ADDR_MASK,    32'h0);
    expect_reg("rst_cap_a",    0, ADDR_EDGECAP, 32'h0);
    expect_reg("rst_cnt_a",    0, ADDR_EDGECNT, 32'h0);
    expect_reg("rst_status_a", 0, ADDR_STATUS,  32'h0000_0400);
    expect_reg("rst_status_b", 1, ADDR_STATUS,  32'h0000_0100);

    // ---- rising capture 0x0 -> 0x5, MASK=0x4, latency 3 clocks ----
    bus_write(0, ADDR_MASK, 32'h4);
    in_a = 4'h5;
    repeat (2) @(negedge clk);
    check("irq_before_lat", {31'h0, irq_a}, 32'h0);
    @(negedge clk);
    check("irq_at_lat", {31'h0, irq_a}, 32'h1);
    expect_reg("cnt_one",     0, ADDR_EDGECNT, 32'h1);
    expect_reg("data_5",      0, ADDR_DATA,    32'h5);
    expect_reg("cap_5",       0, ADDR_EDGECAP, 32'h5);
    expect_reg("status_irq",  0, ADDR_STATUS,  32'h0000_0401);

    // ---- W1C of bit2 drops irq the next cycle ----
    bus_write(0, ADDR_EDGECAP, 32'h4);
    check("irq_after_w1c", {31'h0, irq_a}, 32'h0);
    expect_reg("cap_after_w1c",  0, ADDR_EDGECAP, 32'h1);
    expect_reg("status_no_irq",  0, ADDR_STATUS,  32'h0000_0400);

    // ---- ignored writes, unmapped reads, upper bits ----
    bus_write(0, ADDR_DATA, 32'hFFFF_FFFF);
    expect_reg("data_ro",     0, ADDR_DATA, 32'h5);
    bus_write(0, 3'd5, 32'hFFFF_FFFF);
    expect_reg("addr5_zero",  0, 3'd5, 32'h0);
    bus_write(0, ADDR_STATUS, 32'hFFFF_FFFF);
    expect_reg("status_ro",   0, ADDR_STATUS, 32'h0000_0400);
    bus_write(0, ADDR_MASK, 32'hFFFF_FFFF, 1'b0);
    expect_reg("mask_no_cs",  0, ADDR_MASK, 32'h4);
    bus_write(0, ADDR_MASK, 32'hFFFF_FFFF);
    check("irq_mask_wr", {31'h0, irq_a}, 32'h1);
    expect_reg("mask_width",  0, ADDR_MASK, 32'hF);
    bus_write(0, ADDR_MASK, 32'h4);
    check("irq_mask_restore", {31'h0, irq_a}, 32'h0);

    // ---- W1C alone clears; W1C coinciding with a new edge loses ----
    in_a = 4'h4;
    repeat (4) @(negedge clk);
    expect_reg("fall_ignored", 0, ADDR_EDGECAP, 32'h1);
    bus_write(0, ADDR_EDGECAP, 32'h1);
    expect_reg("w1c_bit0",     0, ADDR_EDGECAP, 32'h0);
    in_a = 4'h5;
    repeat (2) @(negedge clk);
    bus_write(0, ADDR_EDGECAP, 32'h1);
    expect_reg("set_beats_clr", 0, ADDR_EDGECAP, 32'h1);
    expect_reg("cnt_two",       0, ADDR_EDGECNT, 32'h2);

    // ---- any-edge, 10 toggles at 4-clock spacing ----
    for (int i = 0; i < 10; i++) begin
      in_b = ~in_b;
      repeat (4) @(negedge clk);
    end
    expect_reg("cnt_ten_b", 1, ADDR_EDGECNT, 32'd10);
    expect_reg("cap_b",     1, ADDR_EDGECAP, 32'h1);
    expect_reg("data_b",    1, ADDR_DATA,    32'h0);
    check("irq_b_masked", {31'h0, irq_b}, 32'h0);
    bus_write(1, ADDR_MASK, 32'h1);
    check("irq_b_unmasked", {31'h0, irq_b}, 32'h1);
    expect_reg("status_b_irq", 1, ADDR_STATUS, 32'h0000_0101);

    // ---- saturation near 0xFFFFFFFE ----
    force dut_b.edge_cnt = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut_b.edge_cnt;
    expect_reg("cnt_preload", 1, ADDR_EDGECNT, 32'hFFFF_FFFE);
    for (int i = 0; i < 3; i++) begin
      in_b = ~in_b;
      repeat (4) @(negedge clk);
    end
    expect_reg("cnt_saturate", 1, ADDR_EDGECNT, 32'hFFFF_FFFF);

    // ---- counter clear coinciding with an edge: clear wins, cap sets ----
    bus_write(1, ADDR_EDGECAP, 32'h1);
    expect_reg("cap_b_clr", 1, ADDR_EDGECAP, 32'h0);
    in_b = ~in_b;
    repeat (2) @(negedge clk);
    bus_write(1, ADDR_EDGECNT, 32'h0);
    expect_reg("cnt_clr_wins", 1, ADDR_EDGECNT, 32'h0);
    expect_reg("cap_b_on_clr", 1, ADDR_EDGECAP, 32'h1);
    in_b = ~in_b;
    repeat (4) @(negedge clk);
    expect_reg("cnt_after_clr", 1, ADDR_EDGECNT, 32'h1);

    // ---- reset mid-operation with a pending edge in the synchroniser ----
    address_a = ADDR_EDGECAP;
    address_b = ADDR_EDGECNT;
    in_b      = 1'b0;
    @(posedge clk);
    #2;
    check("pre_rst_rdata_a", readdata_a, 32'h1);
    check("pre_rst_rdata_b", readdata_b, 32'h1);
    check("pre_rst_irq_b",   {31'h0, irq_b}, 32'h1);
    reset_n = 1'b0;
    in_a    = 4'h1;
    #1;
    check("mid_rst_rdata_a", readdata_a, 32'h0);
    check("mid_rst_rdata_b", readdata_b, 32'h0);
    check("mid_rst_irq_b",   {31'h0, irq_b}, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // in_a bit0 held high through release -> rising capture after 3 clocks
    repeat (3) @(negedge clk);
    check("hold_cap_early", readdata_a, 32'h0);
    @(negedge clk);
    check("hold_cap_lat", readdata_a, 32'h1);
    expect_reg("post_rst_cnt_a",  0, ADDR_EDGECNT, 32'h1);
    expect_reg("post_rst_mask_a", 0, ADDR_MASK,    32'h0);
    expect_reg("post_rst_data_a", 0, ADDR_DATA,    32'h1);
    expect_reg("post_rst_cnt_b",  1, ADDR_EDGECNT, 32'h0);
    expect_reg("post_rst_cap_b",  1, ADDR_EDGECAP, 32'h0);
    expect_reg("post_rst_mask_b", 1, ADDR_MASK,    32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
